// File: rtl/seven_seg_page_renderer_if.sv
// Byte-stream output bus of the seven-segment page renderer.
// Master produces display column bytes with page/frame tags; slave applies backpressure.
interface seven_seg_page_renderer_if;
   logic [7:0] out_data;
   logic       out_valid;
   logic       out_ready;
   logic [2:0] out_page;
   logic       out_first;
   logic       out_last;

   modport master (
      output out_data,
      output out_valid,
      output out_page,
      output out_first,
      output out_last,
      input  out_ready
   );

   modport slave (
      input  out_data,
      input  out_valid,
      input  out_page,
      input  out_first,
      input  out_last,
      output out_ready
   );
endinterface

// File: rtl/seven_seg_page_renderer.sv
// Renders a row of seven-segment digits into page-organised display bytes,
// one column byte per accepted handshake, page-major then digit then column.
module seven_seg_page_renderer #(
   parameter int DIGITS = 4,
   parameter int PAGES  = 4,
   parameter int CHAR_W = 21,
   parameter int SPACE  = 2,
   parameter int T      = 4
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    start,
   input  logic [8*DIGITS-1:0]     segments_in,
   input  logic                    invert,
   output logic                    busy,
   output logic                    done,
   seven_seg_page_renderer_if.master out_if
);

   localparam int unsigned COL_W = (CHAR_W > 1) ? $clog2(CHAR_W) : 1;
   localparam int unsigned DIG_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

   // Glyph geometry; signed so off-glyph columns (x < 0) compare naturally.
   localparam int H  = 8 * PAGES;
   localparam int GW = CHAR_W - 2 * SPACE;
   localparam int HT = T / 2;
   localparam int HH = H / 2;

   localparam logic [COL_W-1:0] COL_MAX  = COL_W'(CHAR_W - 1);
   localparam logic [DIG_W-1:0] DIG_MAX  = DIG_W'(DIGITS - 1);
   localparam logic [2:0]       PAGE_MAX = 3'(PAGES - 1);

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

   state_t              state_q, state_d;
   logic [COL_W-1:0]    col_q, col_d;
   logic [DIG_W-1:0]    dig_q, dig_d;
   logic [2:0]          page_q, page_d;
   logic [8*DIGITS-1:0] snap_q, snap_d;
   logic                inv_q, inv_d;
   logic [7:0]          data_q, data_d;
   logic                valid_q, valid_d;
   logic                first_q, first_d;
   logic                last_q, last_d;
   logic                busy_q, busy_d;
   logic                done_q, done_d;
   logic                load;
   logic [7:0]          cur_seg;

   // Bit k set when row 8*page+k falls in [lo, hi).
   function automatic logic [7:0] row_mask(input int page, input int lo, input int hi);
      logic [7:0] m;
      int         r;
      m = '0;
      for (int k = 0; k < 8; k++) begin
         r    = 8 * page + k;
         m[k] = (r >= lo) && (r < hi);
      end
      return m;
   endfunction

   function automatic logic [7:0] render(input logic [7:0] seg, input int page, input int col);
      logic [7:0] b;
      int         x;
      logic       x_mid, x_left, x_right, x_dp;
      x       = col - SPACE;
      x_mid   = (x >= HT) && (x < GW - HT);
      x_left  = (x >= 0) && (x < T);
      x_right = (x >= GW - T) && (x < GW);
      x_dp    = (col >= CHAR_W - SPACE) && (col < CHAR_W);
      b = '0;
      if (seg[0] && x_mid)   b |= row_mask(page, 0, T);
      if (seg[1] && x_right) b |= row_mask(page, HT, HH);
      if (seg[2] && x_right) b |= row_mask(page, HH, H - HT);
      if (seg[3] && x_mid)   b |= row_mask(page, H - T, H);
      if (seg[4] && x_left)  b |= row_mask(page, HH, H - HT);
      if (seg[5] && x_left)  b |= row_mask(page, HT, HH);
      if (seg[6] && x_mid)   b |= row_mask(page, HH - HT, HH + HT);
      if (seg[7] && x_dp)    b |= row_mask(page, H - T, H);
      return b;
   endfunction

   // Next-state, counter advance and next output byte.
   always_comb begin
      state_d = state_q;
      col_d   = col_q;
      dig_d   = dig_q;
      page_d  = page_q;
      snap_d  = snap_q;
      inv_d   = inv_q;
      data_d  = data_q;
      valid_d = valid_q;
      first_d = first_q;
      last_d  = last_q;
      busy_d  = busy_q;
      done_d  = 1'b0;
      load    = 1'b0;
      cur_seg = '0;

      case (state_q)
         S_IDLE: begin
            if (start) begin
               state_d = S_RUN;
               snap_d  = segments_in;
               inv_d   = invert;
               col_d   = '0;
               dig_d   = '0;
               page_d  = '0;
               valid_d = 1'b1;
               busy_d  = 1'b1;
               load    = 1'b1;
            end
         end
         S_RUN: begin
            if (out_if.out_ready) begin
               if (last_q) begin
                  state_d = S_DONE;
                  valid_d = 1'b0;
                  busy_d  = 1'b0;
                  done_d  = 1'b1;
                  first_d = 1'b0;
                  last_d  = 1'b0;
               end else begin
                  load = 1'b1;
                  if (col_q == COL_MAX) begin
                     col_d = '0;
                     if (dig_q == DIG_MAX) begin
                        dig_d  = '0;
                        page_d = page_q + 3'd1;
                     end else begin
                        dig_d = dig_q + DIG_W'(1);
                     end
                  end else begin
                     col_d = col_q + COL_W'(1);
                  end
               end
            end
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase

      for (int i = 0; i < DIGITS; i++) begin
         if (dig_d == DIG_W'(i)) cur_seg = snap_d[8*i +: 8];
      end

      // Render from the _d snapshot so the first byte is ready as RUN begins.
      if (load) begin
         data_d  = render(cur_seg, int'(page_d), int'(col_d)) ^ {8{inv_d}};
         first_d = (col_d == '0) && (dig_d == '0);
         last_d  = (col_d == COL_MAX) && (dig_d == DIG_MAX) && (page_d == PAGE_MAX);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= S_IDLE;
         col_q   <= '0;
         dig_q   <= '0;
         page_q  <= '0;
         snap_q  <= '0;
         inv_q   <= 1'b0;
         data_q  <= '0;
         valid_q <= 1'b0;
         first_q <= 1'b0;
         last_q  <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         col_q   <= col_d;
         dig_q   <= dig_d;
         page_q  <= page_d;
         snap_q  <= snap_d;
         inv_q   <= inv_d;
         data_q  <= data_d;
         valid_q <= valid_d;
         first_q <= first_d;
         last_q  <= last_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   assign out_if.out_data  = data_q;
   assign out_if.out_valid = valid_q;
   assign out_if.out_page  = page_q;
   assign out_if.out_first = first_q;
   assign out_if.out_last  = last_q;
   assign busy             = busy_q;
   assign done             = done_q;

endmodule

// File: doc/seven_seg_page_renderer.md
SEVEN_SEG_PAGE_RENDERER -- requirements
Module: seven_seg_page_renderer

Interface
REQ-001 Parameter DIGITS, default 4: number of characters rendered side by side, range 1..8.
REQ-002 Parameter PAGES, default 4: character height in 8-row display pages (H = 8*PAGES rows), range 2..8.
REQ-003 Parameter CHAR_W, default 21: columns per character cell, including leading and trailing space.
REQ-004 Parameter SPACE, default 2: empty columns before the glyph; the same number of columns after it hold the decimal point.
REQ-005 Parameter T, default 4: segment thickness in pixels; legal only if CHAR_W >= 2*SPACE + 2*T + 1 and H >= 4*T.
REQ-006 clk  in  1  single clock; all logic on the rising edge.
REQ-007 reset  in  1  synchronous, active-high reset.
REQ-008 start  in  1  one-cycle request to render one frame.
REQ-009 segments_in  in  8*DIGITS  per digit i, bits [8i+7:8i] = {dp,g,f,e,d,c,b,a}; digit 0 is leftmost.
REQ-010 invert  in  1  when 1, every output byte is bitwise complemented.
REQ-011 out_data  out  8  one display column of one page; bit k = row 8*page+k (LSB = top).
REQ-012 out_valid  out  1  out_data and its tags are valid.
REQ-013 out_ready  in  1  consumer accepts the byte when out_valid && out_ready.
REQ-014 out_page  out  3  page index of the current byte.
REQ-015 out_first  out  1  current byte is the first byte of its page.
REQ-016 out_last  out  1  current byte is the last byte of the frame.
REQ-017 busy  out  1  a frame is in progress.
REQ-018 done  out  1  one-cycle pulse in the cycle after the last byte is accepted.

Function
REQ-019 The FSM SHALL have the states IDLE and RUN, plus DONE, which lasts exactly one cycle, asserts done and returns to IDLE.
REQ-020 In IDLE, start SHALL latch segments_in and invert into snapshot registers, enter RUN and assert busy in the next cycle; input changes after that point SHALL NOT affect the frame.
REQ-021 start SHALL be ignored while busy or in DONE.
REQ-022 out_valid SHALL assert in the first RUN cycle; in that cycle out_data holds page 0, digit 0, column 0.
REQ-023 Byte order SHALL be page-major, then digit, then column: PAGES*DIGITS*CHAR_W bytes per frame (336 at defaults).
REQ-024 Output SHALL be registered; out_data, out_page, out_first and out_last SHALL hold stable while out_valid && !out_ready.
REQ-025 With out_ready held high, the block SHALL sustain one byte per cycle with no bubbles.
REQ-026 Counters SHALL wrap as follows: column goes CHAR_W-1 -> 0 and advances digit; digit goes DIGITS-1 -> 0 and advances page; accepting the byte with page = PAGES-1 and out_last = 1 SHALL enter DONE and deassert out_valid and busy.
REQ-027 Glyph coordinates: x = col - SPACE, with GW = CHAR_W - 2*SPACE; columns with col < SPACE SHALL be 0x00.
REQ-028 Segment pixel sets (x range, rows), half-open intervals:
  - a: [T/2, GW-T/2), [0,T)
  - g: [T/2, GW-T/2), [H/2-T/2, H/2+T/2)
  - d: [T/2, GW-T/2), [H-T, H)
  - f: [0,T), [T/2, H/2)
  - b: [GW-T, GW), [T/2, H/2)
  - e: [0,T), [H/2, H-T/2)
  - c: [GW-T, GW), [H/2, H-T/2)
  - dp: col in [CHAR_W-SPACE, CHAR_W), rows [H-T, H)
REQ-029 A pixel SHALL be 1 if it lies in any enabled segment (bitwise OR of the segment bytes), and 0 otherwise.
REQ-030 Pixel computation SHALL be combinational from the counters and the snapshot, feeding the output register; it SHALL use no ROM larger than 16 entries.

Reset
REQ-031 Reset SHALL force IDLE and clear the counters, the snapshot and every output (out_data 0x00, out_page 0, all flags 0), with priority over start and the handshake.
REQ-032 Reset asserted mid-frame SHALL abort the frame with no done pulse; a start in the first cycle after reset deasserts SHALL be honoured.

Verification
REQ-033 Defaults, digit0 = 8'h06, others 0, ready = 1: col 15 yields 0xFC, 0xFF, 0xFF, 0x3F for pages 0..3; cols 0-1 and 19-20 yield 0x00; done arrives 337 cycles after the start cycle.
REQ-034 Defaults, digit0 = 8'h7F: col 15 page 0 = 0xFF; col 8 yields page 1 0xC0, page 2 0x03, page 3 0xF0, page 0 0x0F.
REQ-035 Digit0 = 8'h80 with invert = 1: cols 19-20 page 3 = 0x0F; all other bytes of digit 0 = 0xFF.
REQ-036 ready toggled randomly, segments_in changed mid-frame: the byte stream equals the ready = 1 stream; out_first is seen exactly at bytes 0, 84, 168 and 252; out_last is seen exactly once.
REQ-037 Reset at byte 100, then start: the frame restarts at page 0, col 0; no done pulse for the aborted frame; start during busy has no effect.
REQ-038 DIGITS = 1, PAGES = 2, CHAR_W = 13, T = 2, digit0 = 8'h08: 26 bytes; cols 3-9 page 1 = 0xC0.
